// File: rtl/craps_autoplay_ctrl.sv
// craps_autoplay_ctrl: plays back-to-back craps games against the game FSM and keeps tallies
module craps_autoplay_ctrl #(
    parameter int PRESS_CYC  = 2,
    parameter int SETTLE_CYC = 2,
    parameter int MAX_ROLLS  = 32,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] games,
    input  logic             win,
    input  logic             lose,
    output logic             Rb,
    output logic             game_rst,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] win_cnt,
    output logic [CNT_W-1:0] lose_cnt,
    output logic [CNT_W-1:0] roll_cnt,
    output logic             err
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] GRST   = 3'd1;
    localparam logic [2:0] PRESS  = 3'd2;
    localparam logic [2:0] SETTLE = 3'd3;
    localparam logic [2:0] CHECK  = 3'd4;
    localparam logic [2:0] NEXT   = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;
    localparam int TW = $clog2((PRESS_CYC > SETTLE_CYC ? PRESS_CYC : SETTLE_CYC) + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]       state, state_nx;
    logic [TW-1:0]    tmr;
    logic [CNT_W-1:0] rem;
    logic             inf, stop_l, launch, active;

    assign active = state != IDLE && state != DONE;
    assign launch = !active && start;

    // next-state decode; a result in CHECK always ends the game, otherwise roll again or abort at the limit
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start ? GRST : state;
            GRST:       state_nx = PRESS;
            PRESS:      state_nx = (tmr == TW'(PRESS_CYC - 1)) ? SETTLE : PRESS;
            SETTLE:     state_nx = (tmr == TW'(SETTLE_CYC - 1)) ? CHECK : SETTLE;
            CHECK:      state_nx = (win || lose) ? NEXT : (roll_cnt == CNT_W'(MAX_ROLLS)) ? DONE : PRESS;
            NEXT:       state_nx = ((!inf && rem == CNT_W'(1)) || stop_l || stop) ? DONE : GRST;
            default:    state_nx = IDLE;
        endcase
    end

    // state, phase timer, registered outputs decoded from the next state, and saturating tallies
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tmr      <= '0;
            rem      <= '0;
            inf      <= 1'b0;
            stop_l   <= 1'b0;
            Rb       <= 1'b0;
            game_rst <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            win_cnt  <= '0;
            lose_cnt <= '0;
            roll_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            tmr      <= (state_nx != state) ? '0 : tmr + TW'(1);
            Rb       <= state_nx == PRESS;
            game_rst <= state_nx == GRST;
            busy     <= state_nx != IDLE && state_nx != DONE;
            done     <= state_nx == DONE;
            if (launch) begin
                win_cnt  <= '0;
                lose_cnt <= '0;
                roll_cnt <= '0;
                err      <= 1'b0;
                rem      <= games;
                inf      <= games == '0;
                stop_l   <= 1'b0;
            end else begin
                if (active && stop)
                    stop_l <= 1'b1;
                if (state_nx == GRST)
                    roll_cnt <= '0;
                if (state_nx == PRESS && state != PRESS && roll_cnt != CNT_MAX)
                    roll_cnt <= roll_cnt + CNT_W'(1);
                if (state == CHECK) begin
                    if (win && !lose && win_cnt != CNT_MAX)
                        win_cnt <= win_cnt + CNT_W'(1);
                    if (lose && lose_cnt != CNT_MAX)
                        lose_cnt <= lose_cnt + CNT_W'(1);
                    if ((win && lose) || state_nx == DONE)
                        err <= 1'b1;
                end
                if (state == NEXT && !inf)
                    rem <= rem - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_craps_autoplay_ctrl.sv
// tb_craps_autoplay_ctrl: scripted craps game model driving the autoplay controller
module tb_craps_autoplay_ctrl;
    localparam int PC = 2;
    localparam int SC = 2;
    localparam int MAXR = 32;

    logic clk = 0, rst = 0, start = 0, stop = 0, win = 0, lose = 0;
    logic [7:0] games = 0;
    logic Rb, game_rst, busy, done, err;
    logic [7:0] win_cnt, lose_cnt, roll_cnt;

    int tests = 0, failed = 0;
    int sc_rolls[$];
    int sc_res[$];
    int gi = -1, rolls = 0, rb_pulses = 0, grst_pulses = 0, viol = 0, hi = 0, lo = 100;
    logic prev_rb = 0;

    craps_autoplay_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .games(games),
        .win(win), .lose(lose), .Rb(Rb), .game_rst(game_rst), .busy(busy),
        .done(done), .win_cnt(win_cnt), .lose_cnt(lose_cnt), .roll_cnt(roll_cnt), .err(err)
    );

    always #5 clk = ~clk;

    // Game FSM stand-in: each game follows its script entry (rolls needed, result 0 none/1 win/2 lose/3 both).
    always @(negedge clk) begin
        if (rst) begin
            win = 0; lose = 0; prev_rb = 0; lo = 100;
        end else begin
            if (game_rst) begin
                grst_pulses++; gi++; rolls = 0; win = 0; lose = 0;
            end
            if (Rb) begin
                if (!prev_rb) begin
                    rb_pulses++;
                    if (lo < SC) viol++;
                    hi = 0;
                end
                hi++;
                if (game_rst) viol++;
            end else begin
                if (prev_rb) begin
                    if (hi != PC) viol++;
                    rolls++;
                    lo = 0;
                    if (gi >= 0 && gi < sc_rolls.size() && sc_res[gi] != 0 && sc_rolls[gi] == rolls) begin
                        win = sc_res[gi][0];
                        lose = sc_res[gi][1];
                    end
                end
                lo++;
            end
            prev_rb = Rb;
        end
    end

    task automatic run_session(input int n, input int stop_game, input int budget, output bit to);
        bit stopped = 0;
        gi = -1; rb_pulses = 0; grst_pulses = 0; viol = 0;
        games = 8'(n); start = 1;
        @(negedge clk);
        start = 0;
        to = 1;
        for (int c = 0; c < budget; c++) begin
            if (done) begin to = 0; break; end
            if (stop_game > 0 && !stopped && grst_pulses == stop_game && Rb) begin
                stop = 1; stopped = 1;
            end else stop = 0;
            @(negedge clk);
        end
        stop = 0;
    endtask

    // Game-by-game prediction straight from the rules: a game with no result aborts the session at the roll limit.
    task automatic predict(input int n, output int ew, output int el, output int er, output int erc, output int erb, output int eg);
        ew = 0; el = 0; er = 0; erc = 0; erb = 0; eg = 0;
        for (int g = 0; g < 1000; g++) begin
            eg++;
            if (g >= sc_rolls.size() || sc_res[g] == 0) begin
                erb += MAXR; erc = MAXR; er = 1; break;
            end
            erb += sc_rolls[g]; erc = sc_rolls[g];
            if (sc_res[g] == 1) ew++;
            else begin
                el++;
                if (sc_res[g] == 3) er = 1;
            end
            if (n != 0 && g + 1 == n) break;
        end
        if (ew > 255) ew = 255;
        if (el > 255) el = 255;
    endtask

    task automatic test_reset;
        logic bad = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        gi = -1; rb_pulses = 0; grst_pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if ({Rb, game_rst, busy, done, err} !== 5'b0 || win_cnt !== 0 || lose_cnt !== 0 || roll_cnt !== 0) bad = 1;
        end
        tests++;
        if (bad !== 0) begin failed++; $display("FAIL reset_outputs: got nonzero output, want all 0"); end
        tests++;
        if (rb_pulses + grst_pulses !== 0) begin failed++; $display("FAIL reset_pulses: got %0d, want 0", rb_pulses + grst_pulses); end
    endtask

    task automatic test_single_game;
        logic [9:0] gr = 0, rb = 0, dn = 0, bz = 0, wc = 0;
        logic [9:0] e_gr = 10'b0000000010, e_rb = 10'b0000001100, e_dn = 10'b1100000000;
        logic [9:0] e_bz = 10'b0011111110, e_wc = 10'b1110000000;
        sc_rolls = {1}; sc_res = {1};
        gi = -1; rb_pulses = 0; grst_pulses = 0; viol = 0;
        games = 1; start = 1;
        @(negedge clk);
        start = 0;
        for (int k = 1; k <= 9; k++) begin
            gr[k] = game_rst; rb[k] = Rb; dn[k] = done; bz[k] = busy; wc[k] = (win_cnt == 1);
            @(negedge clk);
        end
        tests++; if (gr !== e_gr) begin failed++; $display("FAIL single_game_rst: got %b, want %b", gr, e_gr); end
        tests++; if (rb !== e_rb) begin failed++; $display("FAIL single_rb: got %b, want %b", rb, e_rb); end
        tests++; if (dn !== e_dn) begin failed++; $display("FAIL single_done: got %b, want %b", dn, e_dn); end
        tests++; if (bz !== e_bz) begin failed++; $display("FAIL single_busy: got %b, want %b", bz, e_bz); end
        tests++; if (wc !== e_wc) begin failed++; $display("FAIL single_win_timing: got %b, want %b", wc, e_wc); end
        tests++;
        if (lose_cnt !== 0 || roll_cnt !== 1 || err !== 0) begin
            failed++; $display("FAIL single_tallies: got lose=%0d roll=%0d err=%0d, want 0 1 0", lose_cnt, roll_cnt, err);
        end
    endtask

    task automatic test_three_games;
        bit to;
        sc_rolls = {3, 1, 2}; sc_res = {2, 1, 1};
        gi = -1; rb_pulses = 0; grst_pulses = 0; viol = 0;
        games = 3; start = 1;
        @(negedge clk);
        start = 0;
        repeat (8) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        to = 1;
        for (int c = 0; c < 500; c++) begin
            if (done) begin to = 0; break; end
            @(negedge clk);
        end
        tests++; if (to !== 0) begin failed++; $display("FAIL three_timeout: done never rose"); end
        tests++;
        if (win_cnt !== 2 || lose_cnt !== 1 || roll_cnt !== 2) begin
            failed++; $display("FAIL three_tallies: got w=%0d l=%0d r=%0d, want 2 1 2", win_cnt, lose_cnt, roll_cnt);
        end
        tests++;
        if (grst_pulses !== 3 || rb_pulses !== 6 || viol !== 0) begin
            failed++; $display("FAIL three_pulses: got grst=%0d rb=%0d viol=%0d, want 3 6 0", grst_pulses, rb_pulses, viol);
        end
    endtask

    task automatic test_roll_limit;
        bit to;
        sc_rolls.delete(); sc_res.delete();
        run_session(0, 0, 2000, to);
        tests++; if (to !== 0) begin failed++; $display("FAIL limit_timeout: done never rose"); end
        tests++;
        if (rb_pulses !== MAXR || err !== 1 || busy !== 0 || win_cnt !== 0 || lose_cnt !== 0 || roll_cnt !== MAXR) begin
            failed++;
            $display("FAIL roll_limit: got rb=%0d err=%0d busy=%0d w=%0d l=%0d r=%0d, want %0d 1 0 0 0 %0d",
                     rb_pulses, err, busy, win_cnt, lose_cnt, roll_cnt, MAXR, MAXR);
        end
    endtask

    task automatic test_stop;
        bit to;
        sc_rolls.delete(); sc_res.delete();
        for (int i = 0; i < 10; i++) begin sc_rolls.push_back(2); sc_res.push_back(1); end
        run_session(0, 4, 2000, to);
        repeat (3) @(negedge clk);
        tests++; if (to !== 0) begin failed++; $display("FAIL stop_timeout: done never rose"); end
        tests++;
        if (win_cnt !== 4 || grst_pulses !== 4 || roll_cnt !== 2 || done !== 1 || err !== 0) begin
            failed++; $display("FAIL stop_result: got w=%0d grst=%0d r=%0d done=%0d err=%0d, want 4 4 2 1 0",
                               win_cnt, grst_pulses, roll_cnt, done, err);
        end
    endtask

    task automatic test_both_and_restart;
        bit to;
        sc_rolls = {2}; sc_res = {3};
        run_session(1, 0, 500, to);
        tests++;
        if (to !== 0 || err !== 1 || lose_cnt !== 1 || win_cnt !== 0) begin
            failed++; $display("FAIL both_flags: got to=%0d err=%0d l=%0d w=%0d, want 0 1 1 0", to, err, lose_cnt, win_cnt);
        end
        sc_rolls = {1}; sc_res = {1};
        gi = -1; grst_pulses = 0; rb_pulses = 0;
        games = 1; start = 1;
        @(negedge clk);
        start = 0;
        tests++;
        if (err !== 0 || lose_cnt !== 0 || done !== 0 || game_rst !== 1) begin
            failed++; $display("FAIL restart_clear: got err=%0d l=%0d done=%0d grst=%0d, want 0 0 0 1", err, lose_cnt, done, game_rst);
        end
        for (int c = 0; c < 100 && !done; c++) @(negedge clk);
        tests++;
        if (win_cnt !== 1 || err !== 0 || done !== 1) begin
            failed++; $display("FAIL restart_result: got w=%0d err=%0d done=%0d, want 1 0 1", win_cnt, err, done);
        end
    endtask

    task automatic test_rst_mid_press;
        sc_rolls = {5}; sc_res = {1};
        gi = -1; grst_pulses = 0; rb_pulses = 0;
        games = 2; start = 1;
        @(negedge clk);
        start = 0;
        for (int c = 0; c < 20 && !Rb; c++) @(negedge clk);
        rst = 1;
        @(negedge clk);
        tests++;
        if ({Rb, busy, done, game_rst, err} !== 5'b0 || roll_cnt !== 0) begin
            failed++; $display("FAIL rst_mid_press: got Rb=%0d busy=%0d done=%0d grst=%0d err=%0d r=%0d, want all 0",
                               Rb, busy, done, game_rst, err, roll_cnt);
        end
        rst = 0;
        grst_pulses = 0;
        repeat (3) @(negedge clk);
        tests++;
        if (grst_pulses !== 0 || busy !== 0) begin
            failed++; $display("FAIL rst_stays_idle: got grst=%0d busy=%0d, want 0 0", grst_pulses, busy);
        end
    endtask

    task automatic test_random;
        bit to;
        int n, ew, el, er, erc, erb, eg, r;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 5);
            sc_rolls.delete(); sc_res.delete();
            for (int g = 0; g < n; g++) begin
                r = $urandom_range(0, 7);
                sc_rolls.push_back($urandom_range(1, 5));
                sc_res.push_back(r == 0 ? 0 : r == 7 ? 3 : (r % 2) + 1);
            end
            predict(n, ew, el, er, erc, erb, eg);
            run_session(n, 0, 5000, to);
            tests++;
            if (to !== 0 || int'(win_cnt) !== ew || int'(lose_cnt) !== el || int'(err) !== er || int'(roll_cnt) !== erc) begin
                failed++; $display("FAIL random_%0d_tallies: got to=%0d w=%0d l=%0d err=%0d r=%0d, want 0 %0d %0d %0d %0d",
                                   it, to, win_cnt, lose_cnt, err, roll_cnt, ew, el, er, erc);
            end
            tests++;
            if (rb_pulses !== erb || grst_pulses !== eg || viol !== 0) begin
                failed++; $display("FAIL random_%0d_pulses: got rb=%0d grst=%0d viol=%0d, want %0d %0d 0",
                                   it, rb_pulses, grst_pulses, viol, erb, eg);
            end
        end
    endtask

    task automatic test_saturation;
        bit to;
        sc_rolls.delete(); sc_res.delete();
        for (int i = 0; i < 270; i++) begin sc_rolls.push_back(1); sc_res.push_back(1); end
        run_session(0, 258, 10000, to);
        tests++;
        if (to !== 0 || win_cnt !== 255 || grst_pulses !== 258 || lose_cnt !== 0) begin
            failed++; $display("FAIL saturation: got to=%0d w=%0d grst=%0d l=%0d, want 0 255 258 0", to, win_cnt, grst_pulses, lose_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_single_game;
        test_three_games;
        test_roll_limit;
        test_stop;
        test_both_and_restart;
        test_rst_mid_press;
        test_random;
        test_saturation;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/craps_autoplay_ctrl.md
Name: craps_autoplay_ctrl

Overview:
- Player-side controller for the craps game FSM: drives the roll button `Rb` and the per-game reset, then reads back `win`/`lose`.
- Plays a requested number of games back-to-back and keeps win/loss/roll tallies.
- Sits between the board start/stop inputs (or the test harness) and the game FSM. Lets the FPGA build run unattended soak games.

Parameters:
- PRESS_CYC, 2: cycles `Rb` is held high per roll (≥1).
- SETTLE_CYC, 2: cycles after `Rb` falls before `win`/`lose` are sampled (≥1).
- MAX_ROLLS, 32: roll limit per game before abort (≥2).
- CNT_W, 8: width of game-count and tally counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a session; sampled in IDLE only
- stop  in  1  finish the current game, then go to DONE
- games  in  CNT_W  games to play; 0 = play until `stop`
- win  in  1  game FSM win flag
- lose  in  1  game FSM lose flag
- Rb  out  1  roll button to the game FSM
- game_rst  out  1  one-cycle reset pulse to the game FSM
- busy  out  1  session in progress
- done  out  1  session finished; held until `start` or `rst`
- win_cnt  out  CNT_W  games won this session
- lose_cnt  out  CNT_W  games lost this session
- roll_cnt  out  CNT_W  rolls in the current/last game
- err  out  1  sticky: roll limit hit or `win` and `lose` both high

Behaviour:
- Clock/reset: one clock `clk`; synchronous active-high `rst`.
- On `rst`: state=IDLE, all outputs 0.
- `rst` mid-session aborts immediately, with no `game_rst` pulse.
- All outputs are registered.

States:
- IDLE:
  - `start`=1 → clear `win_cnt`, `lose_cnt`, `roll_cnt`, `err`, `done`.
  - Latch `games` into the remaining counter (0 latches as infinite).
  - Go to GRST.
- GRST: `game_rst`=1 for exactly one cycle; clear `roll_cnt`; go to PRESS.
- PRESS:
  - `Rb`=1 for PRESS_CYC consecutive cycles.
  - `roll_cnt` increments once, on PRESS entry.
  - Go to SETTLE.
- SETTLE: `Rb`=0 for SETTLE_CYC cycles; go to CHECK.
- CHECK (single cycle, samples `win`/`lose`):
  - win=1, lose=1 → set `err`, increment `lose_cnt`, go to NEXT.
  - win=1 only → increment `win_cnt`, go to NEXT.
  - lose=1 only → increment `lose_cnt`, go to NEXT.
  - Neither:
    - `roll_cnt` == MAX_ROLLS → set `err`, go to DONE.
    - Otherwise go to PRESS (next roll of the same game).
- NEXT:
  - Decrement the remaining count (not in infinite mode).
  - Remaining hits 0, or `stop` has been latched this session → DONE.
  - Otherwise → GRST.
- DONE:
  - `busy`=0, `done`=1.
  - `start`=1 → behave as IDLE with `start` (new session same cycle).

Rules:
- `busy`=1 in every state except IDLE and DONE.
- `stop`:
  - A one-cycle pulse is latched in any busy state.
  - It never truncates a roll or a game in progress.
  - `stop` in IDLE or DONE is ignored.
- `start` while busy is ignored.
- Tallies saturate at 2^CNT_W−1 and do not wrap.
- `roll_cnt` is held after the game ends, until the next GRST.
- `Rb` is never high in GRST, SETTLE, CHECK, NEXT, IDLE or DONE.
  - Each roll is a clean low→high→low pulse at least SETTLE_CYC low cycles after the previous one.

Latency:
- `start` to first `Rb` rise = 2 cycles (GRST, then PRESS).
- Game with one roll, `start` to CHECK = 2+PRESS_CYC+SETTLE_CYC cycles.

Test Plan:
- `rst` for 2 cycles, then idle 5 cycles → all outputs 0; `Rb` and `game_rst` never pulse.
- games=1; model raises win one cycle after the first `Rb` fall → `game_rst` pulses at cycle 1; `Rb` high exactly cycles 2–3; CHECK at cycle 6; win_cnt=1, lose_cnt=0, roll_cnt=1; `done`=1 with `busy`=0 from cycle 8.
- games=3; model gives lose after 3 rolls, win after 1 roll, win after 2 rolls → win_cnt=2, lose_cnt=1, final roll_cnt=2; exactly 3 `game_rst` pulses; 6 `Rb` pulses.
- games=0; model never asserts a result → 32 `Rb` pulses; err=1; DONE; tallies 0.
- games=0; `stop` pulsed mid-roll of game 4, with games 1–4 all won → game 4 completes; win_cnt=4; DONE; no 5th `game_rst`.
- win and lose both high at CHECK → err=1, lose_cnt +1. Separately, `rst` asserted mid-PRESS → `Rb`=0 and IDLE next cycle; a new `start` clears `err` and tallies.
